// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C monitor: FSM encoding, event record,
// and the helper that builds a short-byte flush record.
package i2c_mon_pkg;

    localparam int BITS_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CLOCK = 2'd1,
        RUN        = 2'd2
    } state_t;

    // One cycle's worth of registered monitor events.
    typedef struct packed {
        logic              valid;
        logic [7:0]        data;
        logic              ack;
        logic [BITS_W-1:0] bits;
        logic              is_short;
        logic              first;
        logic              start;
        logic              stop;
        logic              notrans;
        logic              timeout;
    } mon_evt_t;

    // Partial byte: k bits sit in the low end of the shift register, most
    // recent bit at [0]; left-align them so the first bus bit is the MSB.
    function automatic mon_evt_t flush_evt(input logic [7:0] low,
                                           input logic [BITS_W-1:0] k,
                                           input logic first);
        mon_evt_t e;
        e = '0;
        if (k != '0) begin
            e.valid    = 1'b1;
            e.is_short = 1'b1;
            e.bits     = k;
            e.first    = first;
            e.data     = low << (4'd8 - k);
        end
        return e;
    endfunction

endpackage

// File: rtl/i2c_mon_if.sv
// Bus-side and report-side signals of the I2C monitor.
interface i2c_mon_if;
    import i2c_mon_pkg::*;

    logic              scl_in;
    logic              sda_in;
    logic              scl;
    logic              sda;
    logic              mon_valid;
    logic [7:0]        mon_byte;
    logic              mon_ack;
    logic [BITS_W-1:0] mon_bits;
    logic              mon_short;
    logic              mon_first;
    logic              mon_start;
    logic              mon_stop;
    logic              mon_notrans;
    logic              mon_timeout;
    logic              bus_busy;

    // Monitor side: samples the raw bus, produces reports.
    modport master (
        input  scl_in, sda_in,
        output scl, sda, mon_valid, mon_byte, mon_ack, mon_bits, mon_short,
               mon_first, mon_start, mon_stop, mon_notrans, mon_timeout, bus_busy
    );

    // Consumer side: drives the raw bus, reads reports.
    modport slave (
        output scl_in, sda_in,
        input  scl, sda, mon_valid, mon_byte, mon_ack, mon_bits, mon_short,
               mon_first, mon_start, mon_stop, mon_notrans, mon_timeout, bus_busy
    );

endinterface

// File: rtl/i2c_glitch_filt.sv
// Synchroniser chain followed by a majority-vote window; idles high.
module i2c_glitch_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_LEN-1:0]    win;
    logic [3:0]             ones;

    // Count ones in the vote window.
    always_comb begin
        ones = '0;
        for (int i = 0; i < FILT_LEN; i++)
            ones = ones + 4'(win[i]);
    end

    // Shift through sync flops and window; register the majority decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            win  <= '1;
            out  <= 1'b1;
        end else begin
            sync <= SYNC_STAGES'({sync, in});
            win  <= FILT_LEN'({win, sync[SYNC_STAGES-1]});
            out  <= (ones > 4'(FILT_LEN / 2));
        end
    end

endmodule

// File: rtl/i2c_mon_rx.sv
// Passive I2C monitor: filters SCL/SDA, decodes START/STOP and bytes,
// flushes partial bytes and aborts stuck transactions. Never drives the bus.
module i2c_mon_rx
    import i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic      clk,
    input  logic      reset,
    i2c_mon_if.master bus
);

    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_SAT = '1;

    logic scl_f, sda_f, scl_old, sda_old;
    state_t state, state_nxt;
    logic [8:0] sr, sr_nxt;
    logic [BITS_W-1:0] rx_count, cnt_nxt;
    logic first_pend, fp_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    mon_evt_t ev, ev_nxt;
    logic start_ev, stop_ev, fall, edge_any, to_hit;

    i2c_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .in(bus.scl_in), .out(scl_f));
    i2c_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .in(bus.sda_in), .out(sda_f));

    assign start_ev = scl_f & sda_old & ~sda_f;
    assign stop_ev  = scl_f & ~sda_old & sda_f;
    assign fall     = scl_old & ~scl_f;
    assign edge_any = (scl_f ^ scl_old) | (sda_f ^ sda_old);

    // Next-state, timeout counter and event decode; STOP > START > timeout > fall.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = rx_count;
        fp_nxt    = first_pend;
        ev_nxt    = '0;
        to_nxt    = (state == IDLE || edge_any) ? '0
                  : (to_cnt == TO_SAT) ? to_cnt : to_cnt + 1'b1;
        to_hit    = (TIMEOUT_CYC != 0) && (state != IDLE) && (to_nxt == TO_LIM);
        case (state)
            IDLE: begin
                if (start_ev) begin
                    state_nxt    = WAIT_CLOCK;
                    ev_nxt.start = 1'b1;
                end
            end
            WAIT_CLOCK: begin
                if (stop_ev) begin
                    state_nxt      = IDLE;
                    ev_nxt.stop    = 1'b1;
                    ev_nxt.notrans = 1'b1;
                end else if (to_hit) begin
                    state_nxt      = IDLE;
                    ev_nxt.timeout = 1'b1;
                end else if (fall) begin
                    state_nxt = RUN;
                    sr_nxt    = '0;
                    cnt_nxt   = '0;
                    fp_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (stop_ev) begin
                    ev_nxt      = flush_evt(sr[7:0], rx_count, first_pend);
                    ev_nxt.stop = 1'b1;
                    state_nxt   = IDLE;
                end else if (start_ev) begin
                    ev_nxt       = flush_evt(sr[7:0], rx_count, first_pend);
                    ev_nxt.stop  = 1'b1;
                    ev_nxt.start = 1'b1;
                    state_nxt    = WAIT_CLOCK;
                end else if (to_hit) begin
                    ev_nxt         = flush_evt(sr[7:0], rx_count, first_pend);
                    ev_nxt.timeout = 1'b1;
                    state_nxt      = IDLE;
                end else if (fall) begin
                    sr_nxt = {sr[7:0], sda_f};
                    if (rx_count == 4'd8) begin
                        ev_nxt.valid = 1'b1;
                        ev_nxt.data  = sr_nxt[8:1];
                        ev_nxt.ack   = sr_nxt[0];
                        ev_nxt.bits  = 4'd9;
                        ev_nxt.first = first_pend;
                        fp_nxt       = 1'b0;
                        cnt_nxt      = '0;
                    end else begin
                        cnt_nxt = rx_count + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            rx_count   <= '0;
            first_pend <= 1'b0;
            to_cnt     <= '0;
            scl_old    <= 1'b1;
            sda_old    <= 1'b1;
            ev         <= '0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            rx_count   <= cnt_nxt;
            first_pend <= fp_nxt;
            to_cnt     <= to_nxt;
            scl_old    <= scl_f;
            sda_old    <= sda_f;
            ev         <= ev_nxt;
        end
    end

    assign bus.scl         = scl_f;
    assign bus.sda         = sda_f;
    assign bus.mon_valid   = ev.valid;
    assign bus.mon_byte    = ev.data;
    assign bus.mon_ack     = ev.ack;
    assign bus.mon_bits    = ev.bits;
    assign bus.mon_short   = ev.is_short;
    assign bus.mon_first   = ev.first;
    assign bus.mon_start   = ev.start;
    assign bus.mon_stop    = ev.stop;
    assign bus.mon_notrans = ev.notrans;
    assign bus.mon_timeout = ev.timeout;
    assign bus.bus_busy    = (state != IDLE);

endmodule

// File: tb/tb_i2c_mon_rx.sv
// Directed bench for i2c_mon_rx: bit-banged I2C transfers with expected
// reports worked out by hand.
module tb_i2c_mon_rx;
    import i2c_mon_pkg::*;

    localparam int H = 10;   // bus half-phase in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_mon_if bus_if ();

    i2c_mon_rx #(.SYNC_STAGES(2), .FILT_LEN(5), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .reset(reset), .bus(bus_if.master));

    typedef struct {
        logic [7:0] b;
        logic       ack;
        logic [3:0] bits;
        logic       sh;
        logic       first;
        logic       st;
        logic       sp;
    } rec_t;

    rec_t vq[$];
    int n_start = 0, n_stop = 0, n_notrans = 0, n_to = 0;
    int cyc = 0, t_fall = 0, t_to = 0;
    logic busy_at_to = 1'b1;
    logic scl_prev = 1'b1;
    int checks = 0, failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture pulses on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (bus_if.mon_valid)
            vq.push_back('{bus_if.mon_byte, bus_if.mon_ack, bus_if.mon_bits,
                           bus_if.mon_short, bus_if.mon_first,
                           bus_if.mon_start, bus_if.mon_stop});
        if (bus_if.mon_start) n_start++;
        if (bus_if.mon_stop) n_stop++;
        if (bus_if.mon_stop && bus_if.mon_notrans) n_notrans++;
        if (bus_if.mon_timeout) begin
            n_to++;
            t_to = cyc;
            busy_at_to = bus_if.bus_busy;
        end
        if (scl_prev && !bus_if.scl) t_fall = cyc;
        scl_prev = bus_if.scl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t rec_at(input int i);
        rec_t r;
        r = '{default: '0};
        if (i < vq.size()) r = vq[i];
        return r;
    endfunction

    task automatic clr();
        vq.delete();
        n_start = 0; n_stop = 0; n_notrans = 0; n_to = 0;
    endtask

    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        bus_if.sda_in = 1'b0; cw(H);
        bus_if.scl_in = 1'b0;
    endtask

    task automatic bit_c(input logic b, input logic glitch);
        cw(H);
        bus_if.sda_in = b; cw(H);
        bus_if.scl_in = 1'b1;
        if (glitch) begin
            cw(3); bus_if.scl_in = 1'b0;
            cw(2); bus_if.scl_in = 1'b1;
            cw(5);
        end else cw(H);
        bus_if.scl_in = 1'b0;
    endtask

    task automatic byte_c(input logic [7:0] d, input logic ack, input logic glitch);
        for (int i = 7; i >= 0; i--) bit_c(d[i], glitch);
        bit_c(ack, glitch);
    endtask

    task automatic stop_c();
        cw(H); bus_if.sda_in = 1'b0;
        cw(H); bus_if.scl_in = 1'b1;
        cw(H); bus_if.sda_in = 1'b1;
        cw(3 * H);
    endtask

    rec_t r;

    initial begin
        bus_if.scl_in = 1'b1;
        bus_if.sda_in = 1'b1;
        cw(3);
        chk("rst_scl", 32'(bus_if.scl), 32'd1);
        chk("rst_sda", 32'(bus_if.sda), 32'd1);
        chk("rst_busy", 32'(bus_if.bus_busy), 32'd0);
        chk("rst_valid", 32'(bus_if.mon_valid), 32'd0);
        reset = 1'b0;
        cw(5);

        // Two full bytes then STOP.
        clr();
        start_c(); byte_c(8'hA4, 1'b0, 1'b0); byte_c(8'h5A, 1'b1, 1'b0); stop_c();
        chk("t1_nvalid", 32'(vq.size()), 32'd2);
        r = rec_at(0);
        chk("t1_b0", 32'(r.b), 32'hA4);
        chk("t1_ack0", 32'(r.ack), 32'd0);
        chk("t1_bits0", 32'(r.bits), 32'd9);
        chk("t1_first0", 32'(r.first), 32'd1);
        chk("t1_short0", 32'(r.sh), 32'd0);
        r = rec_at(1);
        chk("t1_b1", 32'(r.b), 32'h5A);
        chk("t1_ack1", 32'(r.ack), 32'd1);
        chk("t1_first1", 32'(r.first), 32'd0);
        chk("t1_nstop", 32'(n_stop), 32'd1);
        chk("t1_notrans", 32'(n_notrans), 32'd0);

        // START immediately followed by STOP.
        clr();
        bus_if.sda_in = 1'b0; cw(H);
        bus_if.sda_in = 1'b1; cw(3 * H);
        chk("t2_start", 32'(n_start), 32'd1);
        chk("t2_stop", 32'(n_stop), 32'd1);
        chk("t2_notrans", 32'(n_notrans), 32'd1);
        chk("t2_nvalid", 32'(vq.size()), 32'd0);

        // Repeated START after bits 1,0,1; then STOP with no data.
        clr();
        start_c(); bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0);
        cw(H); bus_if.sda_in = 1'b1;
        cw(H); bus_if.scl_in = 1'b1;
        cw(H); bus_if.sda_in = 1'b0;
        cw(H); bus_if.sda_in = 1'b1;
        cw(3 * H);
        chk("t3_nvalid", 32'(vq.size()), 32'd1);
        r = rec_at(0);
        chk("t3_short", 32'(r.sh), 32'd1);
        chk("t3_bits", 32'(r.bits), 32'd3);
        chk("t3_byte", 32'(r.b), 32'hA0);
        chk("t3_stop", 32'(r.sp), 32'd1);
        chk("t3_start", 32'(r.st), 32'd1);
        chk("t3_first", 32'(r.first), 32'd1);
        chk("t3_ack", 32'(r.ack), 32'd0);

        // 2-cycle SCL low glitches inside every high phase.
        clr();
        start_c(); byte_c(8'hC3, 1'b0, 1'b1); stop_c();
        chk("t4_nvalid", 32'(vq.size()), 32'd1);
        r = rec_at(0);
        chk("t4_byte", 32'(r.b), 32'hC3);
        chk("t4_ack", 32'(r.ack), 32'd0);
        chk("t4_bits", 32'(r.bits), 32'd9);

        // SCL held low after 4 bits 1,1,0,1.
        clr();
        start_c(); bit_c(1'b1, 1'b0); bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0);
        cw(150);
        chk("t5_nto", 32'(n_to), 32'd1);
        // Filtered SCL falls, scl_old sees it one cycle later, then 100 counts.
        chk("t5_delay", 32'(t_to - t_fall), 32'd101);
        chk("t5_busy", 32'(busy_at_to), 32'd0);
        chk("t5_nvalid", 32'(vq.size()), 32'd1);
        r = rec_at(0);
        chk("t5_short", 32'(r.sh), 32'd1);
        chk("t5_bits", 32'(r.bits), 32'd4);
        chk("t5_byte", 32'(r.b), 32'hD0);
        bus_if.scl_in = 1'b1; cw(3 * H);
        chk("t5_nstop", 32'(n_stop), 32'd0);

        // Reset in the middle of a byte, then a clean transfer.
        clr();
        start_c(); bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0);
        bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0);
        cw(3);
        reset = 1'b1;
        bus_if.scl_in = 1'b1;
        bus_if.sda_in = 1'b1;
        cw(1);
        chk("t6_rst_busy", 32'(bus_if.bus_busy), 32'd0);
        chk("t6_rst_scl", 32'(bus_if.scl), 32'd1);
        cw(5);
        reset = 1'b0;
        cw(3 * H);
        chk("t6_nostale_v", 32'(vq.size()), 32'd0);
        chk("t6_nostale_p", 32'(n_stop), 32'd0);
        clr();
        start_c(); byte_c(8'h3C, 1'b0, 1'b0); stop_c();
        chk("t6_nvalid", 32'(vq.size()), 32'd1);
        r = rec_at(0);
        chk("t6_byte", 32'(r.b), 32'h3C);
        chk("t6_first", 32'(r.first), 32'd1);
        chk("t6_nto", 32'(n_to), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
